uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with optional parity and one or two stop bits
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);
  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_TICKS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);
  localparam logic [AW:0] FULL_CNT = AW1'(FIFO_DEPTH);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic push, pop, empty, bit_end, done_n, line;
  logic par, par_n;
  logic [7:0] head, shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] tick;
  state_t state, state_n;
  assign empty = count == '0;
  assign push = tx_valid_i && tx_ready_o;
  assign head = mem[rd_ptr];
  assign bit_end = tick == TICK_LAST;
  assign count_n = count + AW1'(push) - AW1'(pop);
  // next-state logic; a pop loads the shift register and starts a frame from IDLE or the last stop tick
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    par_n = par;
    pop = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: pop = !empty;
      START: state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_cnt_n = bit_cnt + 3'd1;
        state_n = (bit_cnt == 3'd7) ? ((PARITY != 0) ? PAR_BIT : STOP) : DATA;
      end
      PAR_BIT: if (bit_end) begin
        state_n = STOP;
        bit_cnt_n = '0;
      end
      STOP: if (bit_end) begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == STOP_LAST) begin
          done_n = 1'b1;
          pop = !empty;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n = START;
      shift_n = head;
      par_n = (PARITY == 1) ? ~^head : ^head;
      bit_cnt_n = '0;
    end
  end
  // line level implied by the current state; registered below so tx_o trails the state by one cycle
  always_comb line = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : (state == PAR_BIT) ? par : 1'b1;
  // FIFO storage is not reset; the pointers alone define its contents
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end
  // state, datapath, FIFO pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      tick <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tx_o <= 1'b1;
      tx_ready_o <= 1'b1;
      busy_o <= 1'b0;
      tx_done_o <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      par <= par_n;
      tick <= (state == IDLE || bit_end) ? '0 : tick + 1'b1;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count_n;
      tx_o <= line;
      tx_ready_o <= count_n != FULL_CNT;
      busy_o <= (state != IDLE) || !empty;
      tx_done_o <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench over four transmitter configurations sharing one clock
module tb_uart_tx_fifo;
  localparam int FLEN [4] = '{100, 110, 110, 110};
  localparam bit PE [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] d;
    logic       p;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] vld = '0;
  logic [3:0] ready, tx, busy, done;
  logic [7:0] din [4];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(din[0]), .tx_valid_i(vld[0]), .tx_ready_o(ready[0]),
    .tx_o(tx[0]), .busy_o(busy[0]), .tx_done_o(done[0]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(din[1]), .tx_valid_i(vld[1]), .tx_ready_o(ready[1]),
    .tx_o(tx[1]), .busy_o(busy[1]), .tx_done_o(done[1]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(din[2]), .tx_valid_i(vld[2]), .tx_ready_o(ready[2]),
    .tx_o(tx[2]), .busy_o(busy[2]), .tx_done_o(done[2]));
  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(din[3]), .tx_valid_i(vld[3]), .tx_ready_o(ready[3]),
    .tx_o(tx[3]), .busy_o(busy[3]), .tx_done_o(done[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic end_frame(input int i, input logic [10:0] got, input logic stable, input logic dok);
    exp_t e;
    logic [10:0] want;
    chk($sformatf("dut%0d_frame_expected", i), 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    want = '1;
    want[0] = 1'b0;
    want[8:1] = e.d;
    if (PE[i]) want[9] = e.p;
    chk($sformatf("dut%0d_frame_owner", i), 32'(e.idx), i);
    chk($sformatf("dut%0d_line_bits", i), 32'(got), 32'(want));
    chk($sformatf("dut%0d_bit_stable", i), 32'(stable), 1);
    chk($sformatf("dut%0d_done_timing", i), 32'(dok), 1);
  endtask

  task automatic monitor(input int i);
    logic [10:0] got;
    logic stable, dok, ab;
    int c, b;
    forever begin
      @(negedge clk);
      if (!rst && tx[i] === 1'b0) begin
        got = '1;
        stable = 1'b1;
        dok = 1'b1;
        ab = 1'b0;
        c = 1;
        while (c <= FLEN[i]) begin
          if (rst) begin
            ab = 1'b1;
            break;
          end
          b = (c - 1) / 10;
          if ((c - 1) % 10 == 0) got[b] = tx[i];
          else if (tx[i] !== got[b]) stable = 1'b0;
          if (done[i] !== (c == FLEN[i])) dok = 1'b0;
          c++;
          if (c <= FLEN[i]) @(negedge clk);
        end
        if (!ab) end_frame(i, got, stable, dok);
      end
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic p);
    int t = 0;
    exp_t e;
    vld[i] = 1'b1;
    din[i] = d;
    while (!ready[i] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("dut%0d_send_ready", i), 32'(ready[i]), 1);
    e.idx = 2'(i);
    e.d = d;
    e.p = p;
    sb.push_back(e);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_fall(input int i);
    int t = 0;
    while (tx[i] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("dut%0d_tx_fall", i), 32'(tx[i]), 0);
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    @(negedge clk);
    while ((busy[i] || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("dut%0d_drain", i), 32'(t < 3000), 1);
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, c, acc, nd, nlow;
    foreach (din[k]) din[k] = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'hF);
    chk("rst_ready", 32'(ready), 32'hF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'hA5, 1'b0);
    chk("lat_e0", 32'(tx[0]), 1);
    @(negedge clk);
    chk("lat_e1", 32'(tx[0]), 1);
    @(negedge clk);
    chk("lat_e2", 32'(tx[0]), 0);
    t = 0;
    while (!done[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_cycle", t, 99);
    chk("busy_at_done", 32'(busy[0]), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done[0]), 0);
    chk("busy_after_done", 32'(busy[0]), 0);
    wait_idle(0);
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b0);
    wait_fall(0);
    n = 0;
    c = 0;
    while (n < 3 && c < 400) begin
      c++;
      if (done[0]) n++;
      if (n < 3) @(negedge clk);
    end
    chk("b2b_cycles", c, 300);
    chk("b2b_done_pulses", n, 3);
    wait_idle(0);
    send(0, 8'h40, 1'b0);
    wait_fall(0);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      vld[0] = 1'b1;
      din[0] = 8'h41 + 8'(k);
      if (ready[0]) begin
        acc++;
        sb.push_back({2'd0, din[0], 1'b0});
      end
      @(negedge clk);
    end
    chk("full_ready_low", 32'(ready[0]), 0);
    vld[0] = 1'b0;
    chk("full_accepted", acc, 4);
    wait_idle(0);
    send(1, 8'h07, 1'b1);
    wait_idle(1);
    send(2, 8'h07, 1'b0);
    wait_idle(2);
    send(3, 8'hFF, 1'b0);
    wait_idle(3);
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    wait_fall(0);
    repeat (44) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_ready", 32'(ready[0]), 1);
    chk("abort_done", 32'(done[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    nd = 0;
    nlow = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      nd += int'(done[0]);
      nlow += int'(!tx[0]);
    end
    chk("post_abort_done", nd, 0);
    chk("post_abort_tx_low", nlow, 0);
    chk("post_abort_busy", 32'(busy[0]), 0);
    send(0, 8'h3C, 1'b0);
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
